riscv_dcache_atomic_ctrl: RTL

Sequencer for A-extension memory operations (LR, SC, AMO*) sitting between the memory-stage request and the data-cache array port. It issues the read, drives the combinational AMO ALU, registers its result, issues the write-back with byte mask, and returns the old value or SC status to the core. It also holds the single LR/SC reservation.

---
 rtl/riscv_dcache_atomic_ctrl_if.sv | 57 +++++
 rtl/riscv_dcache_atomic_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/riscv_dcache_atomic_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : riscv_dcache_atomic_ctrl_if
// Desc   : Core, data-cache and AMO-ALU signal bundle of the atomic sequencer.
// Rev    : 1.0
// ============================================================================
interface riscv_dcache_atomic_ctrl_if;
  logic        i_riscv_atomic_req;
  logic [4:0]  i_riscv_atomic_ctrl;
  logic        i_riscv_atomic_xlen;
  logic [63:0] i_riscv_atomic_addr;
  logic [63:0] i_riscv_atomic_rs2data;
  logic        o_riscv_atomic_busy;
  logic        o_riscv_atomic_done;
  logic        o_riscv_atomic_misaligned;
  logic [63:0] o_riscv_atomic_rddata;
  logic        i_riscv_store_valid;
  logic [63:0] i_riscv_store_addr;
  logic        o_mem_rd_req;
  logic [63:0] o_mem_addr;
  logic        i_mem_rvalid;
  logic [63:0] i_mem_rdata;
  logic        o_mem_wr_req;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_wack;
  logic        o_amo_enable;
  logic        o_amo_xlen;
  logic [4:0]  o_amo_ctrl;
  logic [63:0] o_amo_rs1data;
  logic [63:0] o_amo_rs2data;
  logic [63:0] i_amo_result;

  modport slave (
    input  i_riscv_atomic_req, i_riscv_atomic_ctrl, i_riscv_atomic_xlen,
           i_riscv_atomic_addr, i_riscv_atomic_rs2data,
           i_riscv_store_valid, i_riscv_store_addr,
           i_mem_rvalid, i_mem_rdata, i_mem_wack, i_amo_result,
    output o_riscv_atomic_busy, o_riscv_atomic_done, o_riscv_atomic_misaligned,
           o_riscv_atomic_rddata, o_mem_rd_req, o_mem_addr, o_mem_wr_req,
           o_mem_wdata, o_mem_wmask, o_amo_enable, o_amo_xlen, o_amo_ctrl,
           o_amo_rs1data, o_amo_rs2data
  );

  modport master (
    output i_riscv_atomic_req, i_riscv_atomic_ctrl, i_riscv_atomic_xlen,
           i_riscv_atomic_addr, i_riscv_atomic_rs2data,
           i_riscv_store_valid, i_riscv_store_addr,
           i_mem_rvalid, i_mem_rdata, i_mem_wack, i_amo_result,
    input  o_riscv_atomic_busy, o_riscv_atomic_done, o_riscv_atomic_misaligned,
           o_riscv_atomic_rddata, o_mem_rd_req, o_mem_addr, o_mem_wr_req,
           o_mem_wdata, o_mem_wmask, o_amo_enable, o_amo_xlen, o_amo_ctrl,
           o_amo_rs1data, o_amo_rs2data
  );
endinterface
`default_nettype wire

// File: rtl/riscv_dcache_atomic_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : riscv_dcache_atomic_ctrl
// Desc   : LR/SC/AMO sequencer between memory stage and D-cache port.
// Rev    : 1.0
// ============================================================================
module riscv_dcache_atomic_ctrl (
  input  logic                      i_riscv_clk,
  input  logic                      i_riscv_rst,
  riscv_dcache_atomic_ctrl_if.slave bus
);
  localparam logic [4:0] C_LR   = 5'b00010;
  localparam logic [4:0] C_SC   = 5'b00011;
  localparam logic [4:0] C_SWAP = 5'b00001;
  localparam logic [4:0] C_ADD  = 5'b00000;
  localparam logic [4:0] C_XOR  = 5'b00100;
  localparam logic [4:0] C_AND  = 5'b01100;
  localparam logic [4:0] C_OR   = 5'b01000;
  localparam logic [4:0] C_MIN  = 5'b10000;
  localparam logic [4:0] C_MAX  = 5'b10100;
  localparam logic [4:0] C_MINU = 5'b11000;
  localparam logic [4:0] C_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t       r_state, w_next;
  logic [4:0]   r_ctrl;
  logic         r_xlen;
  logic [63:2]  r_addr;
  logic [63:0]  r_rs2, r_old, r_wval, r_rddata;
  logic         r_mis;
  logic         r_resv_valid;
  logic [63:3]  r_resv_addr;

  logic         w_req_ok, w_req_mis, w_req_sc, w_sc_hit, w_accept, w_lr, w_sc;
  logic [63:0]  w_lane;
  logic         w_unused;

  always_comb begin
    w_req_ok = 1'b0;
    case (bus.i_riscv_atomic_ctrl)
      C_LR, C_SC, C_SWAP, C_ADD, C_XOR, C_AND, C_OR,
      C_MIN, C_MAX, C_MINU, C_MAXU: w_req_ok = 1'b1;
      default:                      w_req_ok = 1'b0;
    endcase
  end

  assign w_req_sc  = (bus.i_riscv_atomic_ctrl == C_SC);
  assign w_req_mis = bus.i_riscv_atomic_xlen ? (bus.i_riscv_atomic_addr[2:0] != 3'b000)
                                             : (bus.i_riscv_atomic_addr[1:0] != 2'b00);
  assign w_sc_hit  = r_resv_valid && (r_resv_addr == bus.i_riscv_atomic_addr[63:3]);
  assign w_accept  = (r_state == S_IDLE) && bus.i_riscv_atomic_req;
  assign w_lr      = (r_ctrl == C_LR);
  assign w_sc      = (r_ctrl == C_SC);
  assign w_unused  = ^bus.i_riscv_store_addr[2:0];

  // Word accesses pick the 32-bit lane by addr[2] and sign-extend into rd.
  assign w_lane = r_xlen  ? bus.i_mem_rdata :
                  r_addr[2] ? {{32{bus.i_mem_rdata[63]}}, bus.i_mem_rdata[63:32]}
                            : {{32{bus.i_mem_rdata[31]}}, bus.i_mem_rdata[31:0]};

  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_riscv_atomic_req) begin
          if (!w_req_ok || w_req_mis) w_next = S_DONE;
          else if (w_req_sc)          w_next = w_sc_hit ? S_WRITE : S_DONE;
          else                        w_next = S_READ;
        end
      end
      S_READ:  if (bus.i_mem_rvalid) w_next = w_lr ? S_DONE : S_CALC;
      S_CALC:  w_next = S_WRITE;
      S_WRITE: if (bus.i_mem_wack) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) begin
      r_ctrl   <= 5'd0;
      r_xlen   <= 1'b0;
      r_addr   <= '0;
      r_rs2    <= 64'd0;
      r_old    <= 64'd0;
      r_wval   <= 64'd0;
      r_rddata <= 64'd0;
      r_mis    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ctrl   <= bus.i_riscv_atomic_ctrl;
        r_xlen   <= bus.i_riscv_atomic_xlen;
        r_addr   <= bus.i_riscv_atomic_addr[63:2];
        r_rs2    <= bus.i_riscv_atomic_rs2data;
        r_wval   <= bus.i_riscv_atomic_rs2data;
        r_mis    <= w_req_ok && w_req_mis;
        r_rddata <= (w_req_ok && !w_req_mis && w_req_sc && !w_sc_hit) ? 64'd1 : 64'd0;
      end
      if ((r_state == S_READ) && bus.i_mem_rvalid) begin
        r_old    <= w_lane;
        r_rddata <= w_lane;
      end
      if (r_state == S_CALC) r_wval <= bus.i_amo_result;
    end
  end

  // Ordering matters: a same-cycle LR set must override a snoop kill.
  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) begin
      r_resv_valid <= 1'b0;
      r_resv_addr  <= '0;
    end else begin
      if (bus.i_riscv_store_valid && (bus.i_riscv_store_addr[63:3] == r_resv_addr))
        r_resv_valid <= 1'b0;
      if ((r_state == S_DONE) && w_sc)
        r_resv_valid <= 1'b0;
      if ((r_state == S_READ) && bus.i_mem_rvalid && w_lr) begin
        r_resv_valid <= 1'b1;
        r_resv_addr  <= r_addr[63:3];
      end
    end
  end

  always_comb begin
    bus.o_riscv_atomic_busy       = (r_state != S_IDLE);
    bus.o_riscv_atomic_done       = (r_state == S_DONE);
    bus.o_riscv_atomic_misaligned = (r_state == S_DONE) && r_mis;
    bus.o_riscv_atomic_rddata     = (r_state == S_DONE) ? r_rddata : 64'd0;
    bus.o_mem_rd_req              = (r_state == S_READ);
    bus.o_mem_wr_req              = (r_state == S_WRITE);
    bus.o_mem_addr                = 64'd0;
    bus.o_mem_wdata               = 64'd0;
    bus.o_mem_wmask               = 8'h00;
    bus.o_amo_enable              = 1'b0;
    bus.o_amo_xlen                = 1'b0;
    bus.o_amo_ctrl                = 5'd0;
    bus.o_amo_rs1data             = 64'd0;
    bus.o_amo_rs2data             = 64'd0;
    if ((r_state == S_READ) || (r_state == S_WRITE))
      bus.o_mem_addr = {r_addr[63:3], 3'b000};
    if (r_state == S_WRITE) begin
      bus.o_mem_wdata = r_xlen ? r_wval : {2{r_wval[31:0]}};
      bus.o_mem_wmask = r_xlen ? 8'hFF : (r_addr[2] ? 8'hF0 : 8'h0F);
    end
    if (r_state == S_CALC) begin
      bus.o_amo_enable  = 1'b1;
      bus.o_amo_xlen    = r_xlen;
      bus.o_amo_ctrl    = r_ctrl;
      bus.o_amo_rs1data = r_old;
      bus.o_amo_rs2data = r_xlen ? r_rs2 : {32'd0, r_rs2[31:0]};
    end
  end
endmodule
`default_nettype wire
